// File: rtl/mix_columns_iter_if.sv
// Handshake/data bundle between the substitution/shift stage, the mix stage and AddRoundKey.
// slave = the mix stage itself; master = whatever drives it (upstream producer plus downstream ready).
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         enc_dec;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport slave (
    input  in_valid, state_in, enc_dec, last_round, out_ready,
    output in_ready, out_valid, state_out, busy
  );

  modport master (
    output in_valid, state_in, enc_dec, last_round, out_ready,
    input  in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns: one 32-bit column per clock, fixed 4-cycle latency in all modes.
// Accepts only in IDLE; the result is held in DONE until out_ready, so backpressure stalls indefinitely.
module mix_columns_iter (
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_iter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic         r_enc;
  logic         r_last;
  logic [31:0]  w_col_cur;
  logic [31:0]  w_col_mix;
  logic [31:0]  w_col_new;

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix(input logic [31:0] a, input logic enc);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m2, m3, m9, mb, md, me;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b[i]  = a[31-8*i -: 8];
      x2[i] = f_xtime(b[i]);
      x4[i] = f_xtime(x2[i]);
      x8[i] = f_xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      m2 = x2[i];
      m3 = x2[(i+1)%4] ^ b[(i+1)%4];
      me = x8[i] ^ x4[i] ^ x2[i];
      mb = x8[(i+1)%4] ^ x2[(i+1)%4] ^ b[(i+1)%4];
      md = x8[(i+2)%4] ^ x4[(i+2)%4] ^ b[(i+2)%4];
      m9 = x8[(i+3)%4] ^ b[(i+3)%4];
      if (enc)
        r[31-8*i -: 8] = m2 ^ m3 ^ b[(i+2)%4] ^ b[(i+3)%4];
      else
        r[31-8*i -: 8] = me ^ mb ^ md ^ m9;
    end
    return r;
  endfunction

  always_comb begin
    w_col_cur = '0;
    case (r_col)
      2'd0:    w_col_cur = r_work[127:96];
      2'd1:    w_col_cur = r_work[95:64];
      2'd2:    w_col_cur = r_work[63:32];
      default: w_col_cur = r_work[31:0];
    endcase
  end

  assign w_col_mix = f_mix(w_col_cur, r_enc);
  // Bypass still walks every column so latency does not depend on the mode.
  assign w_col_new = r_last ? w_col_cur : w_col_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)      w_state_nxt = S_CALC;
      S_CALC:  if (r_col == 2'd3)     w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)     w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_col  <= '0;
      r_enc  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work <= bus.state_in;
            r_enc  <= bus.enc_dec;
            r_last <= bus.last_round;
            r_col  <= '0;
          end
        end
        S_CALC: begin
          case (r_col)
            2'd0:    r_work[127:96] <= w_col_new;
            2'd1:    r_work[95:64]  <= w_col_new;
            2'd2:    r_work[63:32]  <= w_col_new;
            default: r_work[31:0]   <= w_col_new;
          endcase
          r_col <= r_col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.state_out = r_work;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter: FIPS-197 vectors, column vectors, bypass with backpressure, mid-CALC reset.
module tb_mix_columns_iter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mix_columns_iter_if ifc ();

  mix_columns_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts one state, waits (bounded) for out_valid, returns the result and the edge count.
  task automatic run(input logic [127:0] st, input logic enc, input logic last,
                     output logic [127:0] res, output int lat);
    @(negedge clk);
    ifc.state_in   = st;
    ifc.enc_dec    = enc;
    ifc.last_round = last;
    ifc.in_valid   = 1'b1;
    ifc.out_ready  = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.out_valid) begin
        lat = n;
        break;
      end
    end
    res = ifc.state_out;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [127:0] res;
  logic [127:0] held;
  int           lat;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.state_in   = '0;
    ifc.enc_dec    = 1'b0;
    ifc.last_round = 1'b0;
    ifc.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  ifc.in_ready,  1);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_busy",      ifc.busy,      0);
    check("rst_state_out", ifc.state_out, 0);

    run(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b0, res, lat);
    check("fips_enc",     res, 128'h046681e5e0cb199a48f8d37a2806264c);
    check("fips_enc_lat", lat, 4);
    check("idle_after_handshake", ifc.in_ready, 1);

    run(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b0, res, lat);
    check("fips_dec",     res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("fips_dec_lat", lat, 4);

    run({4{32'hdb135345}}, 1'b1, 1'b0, res, lat);
    check("col_db_enc", res, {4{32'h8e4da1bc}});
    run({4{32'hf20a225c}}, 1'b1, 1'b0, res, lat);
    check("col_f2_enc", res, {4{32'h9fdc589d}});
    run({4{32'h8e4da1bc}}, 1'b0, 1'b0, res, lat);
    check("col_8e_dec", res, {4{32'hdb135345}});
    run({4{32'hc6c6c6c6}}, 1'b1, 1'b0, res, lat);
    check("col_c6_enc", res, {4{32'hc6c6c6c6}});
    run({4{32'hc6c6c6c6}}, 1'b0, 1'b0, res, lat);
    check("col_c6_dec", res, {4{32'hc6c6c6c6}});

    // Bypass under backpressure, with input churn while busy.
    @(negedge clk);
    ifc.state_in   = 128'h00112233445566778899aabbccddeeff;
    ifc.enc_dec    = 1'b1;
    ifc.last_round = 1'b1;
    ifc.in_valid   = 1'b1;
    ifc.out_ready  = 1'b0;
    @(posedge clk);
    #1;
    ifc.state_in   = 128'hffffffffffffffffffffffffffffffff;
    ifc.last_round = 1'b0;
    ifc.enc_dec    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("byp_out_valid", ifc.out_valid, 1);
    check("byp_result",    ifc.state_out, 128'h00112233445566778899aabbccddeeff);
    for (int i = 0; i < 10; i++) begin
      ifc.state_in = {4{$urandom}};
      @(negedge clk);
      check("byp_hold_data",  ifc.state_out, 128'h00112233445566778899aabbccddeeff);
      check("byp_hold_rdy",   ifc.in_ready,  0);
      check("byp_hold_valid", ifc.out_valid, 1);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("byp_release_rdy",   ifc.in_ready,  1);
    check("byp_release_valid", ifc.out_valid, 0);
    check("byp_release_busy",  ifc.busy,      0);

    // Reset while column 2 is pending.
    @(negedge clk);
    ifc.state_in   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    ifc.enc_dec    = 1'b1;
    ifc.last_round = 1'b0;
    ifc.in_valid   = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_busy", ifc.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  ifc.in_ready,  1);
    check("mid_rst_state_out", ifc.state_out, 0);
    check("mid_rst_out_valid", ifc.out_valid, 0);
    @(posedge clk);
    #1;
    check("mid_rst_held_valid", ifc.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run({4{32'hf20a225c}}, 1'b1, 1'b0, res, lat);
    check("post_rst_result", res, {4{32'h9fdc589d}});
    check("post_rst_lat",    lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
